addsub_serial: RTL and testbench
================================

# addsub_serial

Parametrised, multi-cycle two's-complement adder/subtractor. It processes a WIDTH-bit operation CHUNK bits per clock through a registered carry chain, and reports carry/borrow and signed overflow. It is the wide-operand arithmetic unit for the datapath, where a full-width single-cycle ripple chain would not meet timing. A start/busy/done handshake lets the surrounding controller issue one operation at a time.

## Interface
- WIDTH, 16: operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 4: bits retired per clock. N = WIDTH/CHUNK is the number of compute cycles.
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when busy=0.
- sub  input  1  0 = a+b, 1 = a-b; latched with start.
- a  input  WIDTH  operand A; latched with start.
- b  input  WIDTH  operand B; latched with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result and flags updated.
- result  output  WIDTH  last completed result.
- carry  output  1  carry out of the MSB. For sub, 1 means no borrow and 0 means borrow.
- overflow  output  1  signed overflow of the last completed operation.

## Operation
- Subtraction is computed as a + ~b + 1: the b inversion is applied at latch time and the initial carry-in is set equal to sub.
- FSM states:
  - IDLE: busy=0. start=1 latches a, b', sub and carry-in, clears chunk index k, and moves to RUN.
  - RUN: each edge adds chunk k of a and b' plus the registered carry, stores the CHUNK sum bits into an internal accumulator, registers the chunk carry-out, and increments k. On the edge retiring chunk N-1 the FSM moves to DONE.
  - DONE: lasts one cycle. done=1 and busy=0. start is accepted here exactly as in IDLE, which moves directly to RUN. With start=0 the FSM moves to IDLE.
- result, carry and overflow load only on the edge entering DONE. They hold between completions, so intermediate chunks are never visible.
- overflow = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]).
- start while busy=1 is ignored, with no queueing. Operand changes after the latch edge have no effect.
- Reset in any state, including mid-RUN:
  - FSM returns to IDLE.
  - busy=0, done=0, result=0, carry=0, overflow=0.
  - The aborted operation never signals done.
- WIDTH == CHUNK is legal: N=1, giving a single RUN cycle.

## Timing
- Reset values: busy=0, done=0, result=0, carry=0, overflow=0.
- Edge E0 samples start=1 while busy=0. busy=1 from E0 through E_N.
- Edges E1..E_N retire chunks 0..N-1.
- After E_N: done=1 for exactly one cycle, with busy=0 and result/flags valid.
- Latency from the start-sampling edge to done is N edges.
- Peak throughput is one operation per N+1 edges, reached by asserting start during the done cycle.
- With the defaults (16/4): N=4, busy is high for 4 cycles, and done follows immediately.

## Configuration
- ADDSUB_SAT_EN defined: on overflow=1, result is clamped to the signed limit.
  - a[MSB]=0 clamps to 0111...1.
  - a[MSB]=1 clamps to 1000...0.
  - overflow and carry are still reported unchanged.
- ADDSUB_SAT_EN undefined: result is the raw wrapped WIDTH-bit sum.
- Latency and handshake are identical in both builds.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.
- sub=1, a=0x0005, b=0x0003 -> 4 edges after start: done=1, result=0x0002, carry=1, overflow=0.
- sub=1, a=0x0003, b=0x0005 -> result=0xFFFE, carry=0 (borrow), overflow=0.
- sub=0, a=0x7FFF, b=0x0001 -> overflow=1, carry=0.
  - Without ADDSUB_SAT_EN: result=0x8000.
  - With ADDSUB_SAT_EN: result=0x7FFF.
- sub=1, a=0x8000, b=0x0001 -> overflow=1, carry=1.
  - Without ADDSUB_SAT_EN: result=0x7FFF.
  - With ADDSUB_SAT_EN: result=0x8000.
- Handshake: start pulsed again during busy with different operands -> ignored and result unchanged. start held during the done cycle with a=0xFFFF, b=0x0001, sub=0 -> busy re-asserts next cycle; next done gives result=0x0000, carry=1, overflow=0.
- Reset asserted on the 2nd RUN cycle -> next cycle busy=0, done=0, result=0x0000, carry=0, overflow=0. No done pulse follows until a new start.

Source files
------------

// File: rtl/addsub_serial.sv
// Multi-cycle two's-complement add/sub, CHUNK bits per clock.
// Define ADDSUB_SAT_EN to clamp overflowing results to the signed limit.
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cy_q, cy_d;
  logic             ov_q, ov_d;
  logic [CHUNK:0]   csum;
  logic             ovf;
`ifdef ADDSUB_SAT_EN
  logic [WIDTH-1:0] sat;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cy_d    = cy_q;
    ov_d    = ov_q;
    csum    = '0;
    ovf     = 1'b0;
`ifdef ADDSUB_SAT_EN
    sat     = '0;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          // b is pre-inverted; carry-in supplies the +1
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        csum = {1'b0, a_q[k_q*CHUNK +: CHUNK]}
             + {1'b0, b_q[k_q*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, c_q};
        acc_d[k_q*CHUNK +: CHUNK] = csum[CHUNK-1:0];
        c_d = csum[CHUNK];
        k_d = k_q + KW'(1);
        if (k_q == K_LAST) begin
          ovf = (a_q[WIDTH-1] == b_q[WIDTH-1])
             && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
          state_d = S_DONE;
          cy_d    = csum[CHUNK];
          ov_d    = ovf;
`ifdef ADDSUB_SAT_EN
          sat   = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
          res_d = ovf ? sat : acc_d;
`else
          res_d = acc_d;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      ov_q    <= ov_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign result   = res_q;
  assign carry    = cy_q;
  assign overflow = ov_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial (WIDTH=16, CHUNK=4).
// Expected clamp values follow ADDSUB_SAT_EN when defined.
module tb_addsub_serial;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic        overflow;

  int total = 0;
  int bad   = 0;

`ifdef ADDSUB_SAT_EN
  localparam logic [15:0] EXP_ADD_OV = 16'h7FFF;
  localparam logic [15:0] EXP_SUB_OV = 16'h8000;
`else
  localparam logic [15:0] EXP_ADD_OV = 16'h8000;
  localparam logic [15:0] EXP_SUB_OV = 16'h7FFF;
`endif

  addsub_serial #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .sub(sub),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .result(result),
    .carry(carry),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic s, input logic [15:0] x,
                       input logic [15:0] y);
    start = 1'b1;
    sub   = s;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, result, carry, overflow} !== 19'd0) begin
      bad++;
      $display("FAIL reset_state got b=%b d=%b r=%h c=%b o=%b want all 0",
               busy, done, result, carry, overflow);
    end
    reset = 1'b0;
  endtask

  task automatic test_vec(input string nm, input logic s,
                          input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] er, input logic ec,
                          input logic eo);
    int lat;
    issue(s, x, y);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_busy got %b want 1", nm, busy);
    end
    a = ~x;
    b = ~y;
    wait_done(lat);
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL %s_latency got %0d want 4", nm, lat);
    end
    total++;
    if ({result, carry, overflow, busy} !== {er, ec, eo, 1'b0}) begin
      bad++;
      $display("FAIL %s got r=%h c=%b o=%b busy=%b want r=%h c=%b o=%b busy=0",
               nm, result, carry, overflow, busy, er, ec, eo);
    end
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL %s_done_pulse got %b want 0", nm, done);
    end
  endtask

  task automatic test_arith;
    test_vec("sub_5_3", 1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0);
    test_vec("sub_borrow", 1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0);
    test_vec("add_chain", 1'b0, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0);
    test_vec("add_plain", 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0);
  endtask

  task automatic test_overflow;
    test_vec("add_ovf", 1'b0, 16'h7FFF, 16'h0001, EXP_ADD_OV, 1'b0, 1'b1);
    test_vec("sub_ovf", 1'b1, 16'h8000, 16'h0001, EXP_SUB_OV, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back;
    int lat;
    issue(1'b0, 16'h1234, 16'h0101);
    start = 1'b1;
    sub   = 1'b1;
    a     = 16'hAAAA;
    b     = 16'h5555;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    total++;
    if (lat !== 3 || result !== 16'h1335 || carry !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start got lat=%0d r=%h c=%b want lat=3 r=1335 c=0",
               lat, result, carry);
    end
    start = 1'b1;
    sub   = 1'b0;
    a     = 16'hFFFF;
    b     = 16'h0001;
    @(posedge clk);
    #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL restart_busy got busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(lat);
    total++;
    if (lat !== 4 || {result, carry, overflow} !== {16'h0000, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL b2b got lat=%0d r=%h c=%b o=%b want lat=4 r=0000 c=1 o=0",
               lat, result, carry, overflow);
    end
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL no_queue got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_midrun;
    int seen;
    test_vec("pre_abort", 1'b1, 16'h8000, 16'h0001, EXP_SUB_OV, 1'b1, 1'b1);
    issue(1'b0, 16'h1111, 16'h2222);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    total++;
    if ({busy, done, result, carry, overflow} !== 19'd0) begin
      bad++;
      $display("FAIL abort_state got b=%b d=%b r=%h c=%b o=%b want all 0",
               busy, done, result, carry, overflow);
    end
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL abort_silent got %0d active cycles want 0", seen);
    end
    test_vec("post_abort", 1'b0, 16'h0101, 16'h0202, 16'h0303, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_arith;
    test_overflow;
    test_back_to_back;
    test_reset_midrun;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
